count_ctrl: RTL

//  Front-end controller for the board's up-counter. Synchronises and debounces
//  the raw countup push-button and a clear button, turns each clean press into

---
 rtl/count_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/count_ctrl.sv
// Button front end for the board up-counter: synchronise, debounce, auto-repeat,
// and own the wrapping count register.
module count_ctrl #(
   parameter int WIDTH           = 4,
   parameter int MAX_COUNT       = 9,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 20,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             countup,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             inc_pulse,
   output logic             wrap,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      PRESSED  = 3'd2,
      REPEAT   = 3'd3,
      DB_REL   = 3'd4
   } state_t;

   localparam int TMAX1 = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
   localparam int TMAX  = (TMAX1 > REPEAT_CYCLES) ? TMAX1 : REPEAT_CYCLES;
   localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0]    T_DB   = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]    T_HOLD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]    T_REP  = TW'(REPEAT_CYCLES - 1);
   localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_COUNT);

   state_t          state;
   logic [TW-1:0]   timer;
   logic            cu_meta, cu_s;
   logic            cl_meta, clear_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cu_meta <= 1'b0;
         cu_s    <= 1'b0;
         cl_meta <= 1'b0;
         clear_s <= 1'b0;
      end else begin
         cu_meta <= countup;
         cu_s    <= cu_meta;
         cl_meta <= clear;
         clear_s <= cl_meta;
      end
   end

   // One shared down-counter times debounce, hold-off and repeat intervals.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         timer     <= '0;
         inc_pulse <= 1'b0;
      end else begin
         inc_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (cu_s) begin
                  state <= DB_PRESS;
                  timer <= T_DB;
               end
            end
            DB_PRESS: begin
               if (!cu_s) begin
                  state <= IDLE;
               end else if (timer == '0) begin
                  state     <= PRESSED;
                  inc_pulse <= 1'b1;
                  timer     <= T_HOLD;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            PRESSED: begin
               if (!cu_s) begin
                  state <= DB_REL;
                  timer <= T_DB;
               end else if (timer == '0) begin
                  state     <= REPEAT;
                  inc_pulse <= 1'b1;
                  timer     <= T_REP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            REPEAT: begin
               if (!cu_s) begin
                  state <= DB_REL;
                  timer <= T_DB;
               end else if (timer == '0) begin
                  inc_pulse <= 1'b1;
                  timer     <= T_REP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            DB_REL: begin
               // A re-press during release debounce restarts the hold-off without counting.
               if (cu_s) begin
                  state <= PRESSED;
                  timer <= T_HOLD;
               end else if (timer == '0) begin
                  state <= IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

   // Clear wins over a coincident increment; the strobe itself is unaffected.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear_s) begin
            count <= '0;
         end else if (inc_pulse) begin
            if (count == C_MAX) begin
               count <= '0;
               wrap  <= 1'b1;
            end else begin
               count <= count + WIDTH'(1);
            end
         end
      end
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule
